// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and funct3 width codes for the load/store unit
package load_store_unit_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  byte_en_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane steering and load extraction/extension
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0] st_funct3,
   input  logic [1:0] st_offset,
   input  data_t      st_data,
   output byte_en_t   st_be,
   output data_t      st_wdata,
   input  logic [2:0] ld_funct3,
   input  logic [1:0] ld_offset,
   input  data_t      ld_rdata,
   output data_t      ld_data
);

   function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] off,
                                               input data_t d);
      byte_en_t be;
      data_t    wd;
      case (f3)
         F3_B:    begin be = 4'b0001 << off; wd = {4{d[7:0]}};  end
         F3_H:    begin be = 4'b0011 << off; wd = {2{d[15:0]}}; end
         F3_W:    begin be = 4'b1111;        wd = d;            end
         default: begin be = 4'b0000;        wd = '0;           end
      endcase
      return {be, wd};
   endfunction

   function automatic data_t load_extend(input logic [2:0] f3, input logic [1:0] off,
                                         input data_t d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{off, 3'b000} +: 8];
      h = off[1] ? d[31:16] : d[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'd0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'd0, h};
         F3_W:    return d;
         default: return '0;
      endcase
   endfunction

   assign {st_be, st_wdata} = store_lanes(st_funct3, st_offset, st_data);
   assign ld_data           = load_extend(ld_funct3, ld_offset, ld_rdata);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multicycle load/store stage driving a req/ack data-memory port
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic        illegal,
   output logic        bus_error,
   output logic [31:0] load_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   lsu_state_t    state;
   logic          st_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   data_t         rdata_q;
   logic          err_ill;
   logic          err_mis;
   logic [CW-1:0] wait_cnt;
   logic          f3_legal;
   logic          f3_mis;
   byte_en_t      st_be;
   data_t         st_wdata;
   data_t         ld_ext;

   lsu_align u_align (
      .st_funct3 (funct3),
      .st_offset (addr[1:0]),
      .st_data   (store_data),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (f3_q),
      .ld_offset (off_q),
      .ld_rdata  (mem_rdata),
      .ld_data   (ld_ext)
   );

   always_comb begin
      f3_legal = is_store ? (funct3 inside {F3_B, F3_H, F3_W})
                          : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      f3_mis   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                 (funct3 == F3_W && addr[1:0] != 2'b00);
   end

   // Rejected accesses pass through RESP so their done lands one cycle after RESP like any other
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         st_q       <= 1'b0;
         f3_q       <= '0;
         off_q      <= '0;
         rdata_q    <= '0;
         err_ill    <= 1'b0;
         err_mis    <= 1'b0;
         wait_cnt   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         illegal    <= 1'b0;
         bus_error  <= 1'b0;
         load_data  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               st_q     <= is_store;
               f3_q     <= funct3;
               off_q    <= addr[1:0];
               wait_cnt <= '0;
               busy     <= 1'b1;
               err_ill  <= !f3_legal;
               err_mis  <= f3_legal && f3_mis;
               if (!f3_legal || f3_mis) begin
                  state <= S_RESP;
               end else begin
                  state     <= S_REQ;
                  mem_req   <= 1'b1;
                  mem_we    <= is_store;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_be    <= is_store ? st_be : 4'b1111;
                  mem_wdata <= is_store ? st_wdata : '0;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  rdata_q <= ld_ext;
                  state   <= S_RESP;
               end else if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT - 1)) begin
                  mem_req   <= 1'b0;
                  bus_error <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (!st_q && !err_ill && !err_mis)
                  load_data <= rdata_q;
               illegal    <= err_ill;
               misaligned <= err_mis;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= S_DONE;
            end
            S_DONE: begin
               done       <= 1'b0;
               illegal    <= 1'b0;
               misaligned <= 1'b0;
               bus_error  <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against an arithmetic model
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        busy, done, misaligned, illegal, bus_error;
   logic [31:0] load_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int n_checks = 0;
   int n_err = 0;
   logic [31:0] exp_ld = '0;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
      .addr(addr), .store_data(store_data), .busy(busy), .done(done),
      .misaligned(misaligned), .illegal(illegal), .bus_error(bus_error),
      .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction: start in cycle 0, ack after `waits` idle REQ cycles, checked against the model
   task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int waits,
                          input bit poke_busy);
      int o, c, done_c, req_cycles, exp_done_c, exp_req;
      bit legal, mis, timeout, err;
      logic [3:0]  ebe;
      logic [31:0] ewd, eld, b, h;
      o = int'(a[1:0]);
      legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
      err = !legal || mis;
      timeout = !err && (waits >= TO);
      ebe = 4'hf; ewd = sd;
      if (st && f3 == 3'd0) begin ebe = 4'(1 << o); ewd = (sd & 32'hff) * 32'h01010101; end
      if (st && f3 == 3'd1) begin ebe = 4'(3 << o); ewd = (sd & 32'hffff) * 32'h00010001; end
      b = (rd >> (8 * o)) & 32'hff;
      h = (rd >> (16 * (o / 2))) & 32'hffff;
      case (f3)
         3'd0: eld = (b >= 32'h80) ? (b | 32'hffffff00) : b;
         3'd1: eld = (h >= 32'h8000) ? (h | 32'hffff0000) : h;
         3'd4: eld = b;
         3'd5: eld = h;
         default: eld = rd;
      endcase
      if (!st && !err && !timeout) exp_ld = eld;
      exp_done_c = err ? 2 : (timeout ? TO + 1 : waits + 3);
      exp_req    = err ? 0 : (timeout ? TO : waits + 1);

      @(negedge clk);
      start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
      @(negedge clk);
      c = 1; done_c = -1; req_cycles = 0;
      while (c < 30 && done_c < 0) begin
         start = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
         if (poke_busy && c == 2) begin
            start = 1'b1; is_store = ~st; funct3 = 3'd0; addr = 32'h0; store_data = $urandom;
         end
         if (c == 1) chk("busy", {31'd0, busy}, 32'd1);
         if (mem_req) begin
            req_cycles++;
            if (req_cycles == 1) begin
               chk("mem_addr", mem_addr, a & 32'hfffffffc);
               chk("mem_we", {31'd0, mem_we}, {31'd0, st});
               chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
               if (st) chk("mem_wdata", mem_wdata, ewd);
            end
            if (req_cycles == waits + 1) begin mem_ack = 1'b1; mem_rdata = rd; end
         end
         if (done) begin
            done_c = c;
            chk("done_cycle", done_c, exp_done_c);
            chk("req_cycles", req_cycles, exp_req);
            chk("illegal", {31'd0, illegal}, {31'd0, !legal});
            chk("misaligned", {31'd0, misaligned}, {31'd0, legal && mis});
            chk("bus_error", {31'd0, bus_error}, {31'd0, timeout});
            chk("load_data", load_data, exp_ld);
            chk("mem_req_at_done", {31'd0, mem_req}, 32'd0);
         end else begin
            @(negedge clk);
            c++;
         end
      end
      if (done_c < 0) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b0;
      chk("done_falls", {28'd0, done, misaligned, illegal, bus_error}, 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_outputs", {27'd0, busy, done, misaligned, illegal, bus_error}, 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_mem", {29'd0, mem_req, mem_we, |mem_be} | mem_addr | mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hdeadbeef, 0, 1'b0);
      chk("lw_value", load_data, 32'hdeadbeef);
      run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80aabbcc, 3, 1'b1);
      chk("lb_value", load_data, 32'hffffff80);
      run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80aabbcc, 3, 1'b0);
      chk("lbu_value", load_data, 32'h00000080);
      run_txn(1'b1, 3'b001, 32'h202, 32'h1234abcd, 32'h0, 1, 1'b1);
      chk("sh_keeps_load", load_data, 32'h00000080);
      run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b0);
      run_txn(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1);
      run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 100, 1'b0);

      for (int i = 0; i < 40; i++)
         run_txn(1'(($urandom & 1)), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 5)), 1'(($urandom & 1)));

      @(negedge clk);
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_req_before", {31'd0, mem_req}, 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_outputs", {27'd0, busy, done, misaligned, illegal, bus_error}, 32'd0);
      chk("abort_mem", {29'd0, mem_req, mem_we, |mem_be} | mem_addr | mem_wdata, 32'd0);
      chk("abort_load_data", load_data, 32'd0);
      exp_ld = '0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_done", {30'd0, done, mem_req}, 32'd0);
      end
      run_txn(1'b0, 3'b101, 32'h502, 32'h0, 32'h9abc1234, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
